// File: rtl/pc_branch_unit.sv
// Program-counter and branch-resolution stage for the single-cycle RV32I core.
// Resolves branch/JAL/JALR redirects, traps misaligned targets and counts retirement.
module pc_branch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch,
  input  logic        jump,
  input  logic        jalr,
  input  logic [2:0]  funct3,
  input  logic [31:0] imm_ext,
  input  logic [31:0] alu_result,
  input  logic        Z,
  input  logic        N,
  input  logic        V,
  input  logic        C,
  input  logic        trap_clear,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] pc_target,
  output logic        taken,
  output logic        trap,
  output logic [31:0] trap_addr,
  output logic [31:0] instr_count,
  output logic [31:0] branch_count
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_TRAP = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] trap_addr_q, trap_addr_d;
  logic [31:0] instr_count_q, instr_count_d;
  logic [31:0] branch_count_q, branch_count_d;
  logic        trap_q, trap_d;

  logic        cond_s;
  logic        taken_s;
  logic        misaligned_s;
  logic [31:0] pc_plus4_s;
  logic [31:0] pc_rel_s;
  logic [31:0] pc_target_s;
  logic [31:0] pc_adv_s;
  logic [31:0] branch_inc_s;

  // Branch condition decode from the ALU flags of rs1 - rs2
  always_comb begin
    cond_s = 1'b0;
    case (funct3)
      3'b000:  cond_s = Z;
      3'b001:  cond_s = ~Z;
      3'b100:  cond_s = N ^ V;
      3'b101:  cond_s = ~(N ^ V);
      3'b110:  cond_s = ~C;
      3'b111:  cond_s = C;
      default: cond_s = 1'b0;
    endcase
  end

  // Redirect target selection, JALR has priority over JAL over branches
  always_comb begin
    pc_plus4_s  = pc_q + 32'd4;
    pc_rel_s    = pc_q + imm_ext;
    pc_target_s = pc_rel_s;
    taken_s     = 1'b0;
    if (jalr) begin
      pc_target_s = alu_result & ~32'h0000_0001;
      taken_s     = 1'b1;
    end else if (jump) begin
      taken_s = 1'b1;
    end else if (branch) begin
      taken_s = cond_s;
    end else begin
      taken_s = 1'b0;
    end
    misaligned_s = taken_s && (pc_target_s[1:0] != 2'b00);
    pc_adv_s     = taken_s ? pc_target_s : pc_plus4_s;
    branch_inc_s = taken_s ? 32'd1 : 32'd0;
  end

  // Next-state and next-value logic for PC, trap FSM and counters
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    trap_addr_d    = trap_addr_q;
    branch_count_d = branch_count_q;
    case (state_q)
      ST_RUN: begin
        if (stall) begin
          state_d = ST_RUN;
        end else if (misaligned_s) begin
          pc_d        = TRAP_VECTOR;
          trap_addr_d = pc_target_s;
          state_d     = ST_TRAP;
        end else begin
          pc_d           = pc_adv_s;
          branch_count_d = branch_count_q + branch_inc_s;
        end
      end
      ST_TRAP: begin
        // The handler acknowledge is honoured even while the pipeline is stalled
        if (stall) begin
          if (trap_clear) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_TRAP;
          end
        end else if (misaligned_s) begin
          trap_addr_d = pc_target_s;
          if (trap_clear) begin
            pc_d    = TRAP_VECTOR;
            state_d = ST_TRAP;
          end else begin
            state_d = ST_HALT;
          end
        end else begin
          pc_d           = pc_adv_s;
          branch_count_d = branch_count_q + branch_inc_s;
          if (trap_clear) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_TRAP;
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase

    if (!stall && (state_q != ST_HALT)) begin
      instr_count_d = instr_count_q + 32'd1;
    end else begin
      instr_count_d = instr_count_q;
    end
    trap_d = (state_d != ST_RUN);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_RUN;
      pc_q           <= RESET_PC;
      trap_q         <= 1'b0;
      trap_addr_q    <= 32'h0000_0000;
      instr_count_q  <= 32'h0000_0000;
      branch_count_q <= 32'h0000_0000;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      trap_q         <= trap_d;
      trap_addr_q    <= trap_addr_d;
      instr_count_q  <= instr_count_d;
      branch_count_q <= branch_count_d;
    end
  end

  assign pc           = pc_q;
  assign pc_plus4     = pc_plus4_s;
  assign pc_target    = pc_target_s;
  assign taken        = taken_s;
  assign trap         = trap_q;
  assign trap_addr    = trap_addr_q;
  assign instr_count  = instr_count_q;
  assign branch_count = branch_count_q;

endmodule
